data_mem_responder: RTL and testbench

//   Responder end of the core's data-memory port. Accepts one load/store request from the M stage

---
 rtl/data_mem_responder_pkg.sv | 17 +
 rtl/mem_lane_align.sv | 42 ++++
 rtl/data_mem_responder.sv | 126 ++++++++++++
 tb/tb_data_mem_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes and FSM states.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_BAD  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for sized accesses: store merge, load extract/extend, misalign detect.
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  size_e       i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_sext,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_old_word,
    output logic [31:0] o_merged,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [31:0] w_shift;

    assign w_shift = i_old_word >> {i_addr_lo, 3'b000};

    always_comb begin
        o_merged   = i_old_word;
        o_rdata    = '0;
        o_misalign = 1'b0;
        case (i_size)
            SIZE_BYTE: begin
                o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
                o_rdata = {{24{i_sext & w_shift[7]}}, w_shift[7:0]};
            end
            SIZE_HALF: begin
                o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
                o_rdata    = {{16{i_sext & w_shift[15]}}, w_shift[15:0]};
                o_misalign = i_addr_lo[0];
            end
            SIZE_WORD: begin
                o_merged   = i_wdata;
                o_rdata    = i_old_word;
                o_misalign = |i_addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Latency-programmable responder for the core's data-memory port: accept, wait, access RAM, respond.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    state_e                  r_state, w_next;
    logic [3:0]              r_cnt;
    logic                    r_write, r_sext;
    size_e                   r_size;
    logic [31:0]             r_addr, r_wdata, r_pc;
    logic [31:0]             r_rdata;
    logic                    r_err;
    logic [31:0]             r_mem [DEPTH];

    logic                    w_accept, w_exec, w_oor, w_misalign, w_err;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [31:0]             w_old, w_merged, w_load;

    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_exec   = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_idx    = r_addr[ADDR_WIDTH+1:2];
    assign w_oor    = |r_addr[31:ADDR_WIDTH+2];
    assign w_err    = w_misalign || (r_size == SIZE_BAD) || w_oor;
    assign w_old    = r_mem[w_idx];

    mem_lane_align u_align (
        .i_size     (r_size),
        .i_addr_lo  (r_addr[1:0]),
        .i_sext     (r_sext),
        .i_wdata    (r_wdata),
        .i_old_word (w_old),
        .o_merged   (w_merged),
        .o_rdata    (w_load),
        .o_misalign (w_misalign)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid)  w_next = S_WAIT;
            S_WAIT:  if (w_exec)     w_next = S_RESP;
            S_RESP:  if (resp_ready) w_next = S_IDLE;
            default:                 w_next = S_IDLE;
        endcase
    end

    // Request fields are captured only on the accept edge; the wait counter is loaded alongside.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_sext  <= 1'b0;
            r_size  <= SIZE_BYTE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_pc    <= '0;
        end else if (w_accept) begin
            r_cnt   <= CNT_INIT;
            r_write <= req_write;
            r_sext  <= req_sext;
            r_size  <= size_e'(req_size);
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_pc    <= req_pc;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_exec) begin
            r_err   <= w_err;
            r_rdata <= (w_err || r_write) ? 32'd0 : w_load;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_exec && r_write && !w_err) begin
            r_mem[w_idx] <= w_merged;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && w_exec && r_write && !w_err)
            $display("%d@%h: *%h <= %h", $time, r_pc, {r_addr[31:2], 2'b00}, w_merged);
    end
`endif

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: lanes, errors, backpressure, reset abort, latency builds.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid_l;
    logic        req_write, req_sext;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, req_pc;
    logic        resp_ready;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        l1_rdy_in = 1'b1;
    logic        l1_req_ready, l1_resp_valid, l1_resp_err;
    logic [31:0] l1_resp_rdata;
    logic        l15_req_ready, l15_resp_valid, l15_resp_err;
    logic [31:0] l15_resp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(12), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_sext(req_sext),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_responder #(.ADDR_WIDTH(12), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .req_valid(req_valid_l), .req_ready(l1_req_ready),
        .req_write(req_write), .req_size(req_size), .req_sext(req_sext),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(l1_resp_valid), .resp_ready(l1_rdy_in),
        .resp_rdata(l1_resp_rdata), .resp_err(l1_resp_err)
    );

    data_mem_responder #(.ADDR_WIDTH(12), .LATENCY(15)) dut_l15 (
        .clk(clk), .reset(reset), .req_valid(req_valid_l), .req_ready(l15_req_ready),
        .req_write(req_write), .req_size(req_size), .req_sext(req_sext),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(l15_resp_valid), .resp_ready(l1_rdy_in),
        .resp_rdata(l15_resp_rdata), .resp_err(l15_resp_err)
    );

    task automatic drive_req(input logic w, input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [31:0] wd);
        req_write = w; req_size = sz; req_sext = sx;
        req_addr  = a; req_wdata = wd; req_pc = 32'h0000_1000 + a;
    endtask

    // One full transaction with resp_ready held high; lat counts edges from accept to resp_valid.
    task automatic xact(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        drive_req(w, sz, sx, a, wd);
        req_valid = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        drive_req(1'b0, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (resp_valid !== 1'b1 && lat < 40);
        rd = resp_rdata; er = resp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_valid_l = 1'b0; resp_ready = 1'b0;
        drive_req(1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        total++; if (resp_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", resp_err); end
    endtask

    task automatic test_basic;
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678, rd, er, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        total++; if (er !== 1'b0 || rd !== 32'd0) begin bad++; $display("FAIL sw_resp got=%b/%h exp=0/00000000", er, rd); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_resp got=%b exp=1", req_ready); end
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h1234_5678 || er !== 1'b0) begin bad++; $display("FAIL lw_10 got=%h/%b exp=12345678/0", rd, er); end
    endtask

    task automatic test_lanes;
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 2'd0, 1'b0, 32'h13, 32'hFFFF_FFAB, rd, er, lat);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hAB34_5678) begin bad++; $display("FAIL sb_merge got=%h exp=ab345678", rd); end
        xact(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hFFFF_FFAB) begin bad++; $display("FAIL lb_13 got=%h exp=ffffffab", rd); end
        xact(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h0000_00AB) begin bad++; $display("FAIL lbu_13 got=%h exp=000000ab", rd); end
        xact(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h0000_0056) begin bad++; $display("FAIL lb_11 got=%h exp=00000056", rd); end
        xact(1'b1, 2'd1, 1'b0, 32'h10, 32'h1234_8001, rd, er, lat);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hAB34_8001) begin bad++; $display("FAIL sh_merge got=%h exp=ab348001", rd); end
        xact(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_10 got=%h exp=ffff8001", rd); end
        xact(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hFFFF_AB34) begin bad++; $display("FAIL lh_12 got=%h exp=ffffab34", rd); end
        xact(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h0000_AB34) begin bad++; $display("FAIL lhu_12 got=%h exp=0000ab34", rd); end
        xact(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hAB34_8001) begin bad++; $display("FAIL lw_sext_ignored got=%h exp=ab348001", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lat;
        xact(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, rd, er, lat);
        total++; if (er !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL lw_misalign got=%b/%h exp=1/00000000", er, rd); end
        total++; if (lat !== 2) begin bad++; $display("FAIL err_latency got=%0d exp=2", lat); end
        xact(1'b1, 2'd1, 1'b0, 32'h13, 32'h0000_FFFF, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL sh_misalign got=%b exp=1", er); end
        xact(1'b1, 2'd3, 1'b0, 32'h10, 32'h0000_0000, rd, er, lat);
        total++; if (er !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL size3_store got=%b/%h exp=1/00000000", er, rd); end
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hAB34_8001 || er !== 1'b0) begin bad++; $display("FAIL err_no_write got=%h/%b exp=ab348001/0", rd, er); end
        xact(1'b1, 2'd2, 1'b0, 32'h4000, 32'hDEAD_0000, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL sw_out_of_range got=%b exp=1", er); end
        xact(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, er, lat);
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL oor_no_alias got=%h exp=00000000", rd); end
        xact(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, rd, er, lat);
        total++; if (er !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL size3_load got=%b/%h exp=1/00000000", er, rd); end
        xact(1'b1, 2'd2, 1'b0, 32'h3FFC, 32'hDEAD_BEEF, rd, er, lat);
        xact(1'b0, 2'd2, 1'b0, 32'h3FFC, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin bad++; $display("FAIL last_word got=%h/%b exp=deadbeef/0", rd, er); end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd; logic er; int lat;
        drive_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_rise got=%b exp=1", resp_valid); end
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                drive_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h0);
                req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk); #1;
            total++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hAB34_8001 || resp_err !== 1'b0 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold c=%0d got v=%b d=%h e=%b rdy=%b exp v=1 d=ab348001 e=0 rdy=0",
                         c, resp_valid, resp_rdata, resp_err, req_ready);
            end
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", resp_valid, req_ready); end
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hAB34_8001) begin bad++; $display("FAIL bp_pulse_ignored got=%h exp=ab348001", rd); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int lat;
        drive_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h5555_AAAA);
        req_valid = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", req_ready); end
        lat = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b0) lat++;
        end
        total++; if (lat !== 0) begin bad++; $display("FAIL rst_mid_no_resp got=%0d exp=0 cycles valid", lat); end
        xact(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat);
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL rst_mid_no_write got=%h exp=00000000", rd); end
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL rst_clears_ram got=%h exp=00000000", rd); end
    endtask

    task automatic test_latency_builds;
        int e1 = -1;
        int e15 = -1;
        drive_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        total++; if (l1_req_ready !== 1'b1 || l15_req_ready !== 1'b1) begin bad++; $display("FAIL lat_idle got=%b/%b exp=1/1", l1_req_ready, l15_req_ready); end
        req_valid_l = 1'b1;
        @(posedge clk); #1;
        req_valid_l = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (e1 < 0 && l1_resp_valid === 1'b1) e1 = n;
            if (e15 < 0 && l15_resp_valid === 1'b1) e15 = n;
        end
        total++; if (e1 !== 1) begin bad++; $display("FAIL latency1 got=%0d exp=1", e1); end
        total++; if (e15 !== 15) begin bad++; $display("FAIL latency15 got=%0d exp=15", e15); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_lanes;
        test_errors;
        test_backpressure;
        test_reset_mid;
        test_latency_builds;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
